// File: rtl/multi_buffer_swap_controller_pkg.sv
// Shared encodings for the frame-buffer swap controller and its ready-index queue.
// Latency: n/a (types, constants and the index-width macro only).
// Backpressure: n/a.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 2) ? 1 : $clog2(x))
`endif

package multi_buffer_swap_controller_pkg;

    // Per-buffer ownership state.
    typedef enum logic [1:0] {
        BUF_FREE       = 2'd0,
        BUF_RENDERING  = 2'd1,
        BUF_READY      = 2'd2,
        BUF_DISPLAYING = 2'd3
    } buf_state_e;

    // One-hot raster-side sequencer states.
    typedef enum logic [3:0] {
        RS_FRAME_READY         = 4'b0001,
        RS_RASTER_IN_PROGRESS  = 4'b0010,
        RS_FRAME_FINISHED      = 4'b0100,
        RS_ALLOCATE            = 4'b1000
    } raster_state_e;

endpackage

// File: rtl/multi_buffer_swap_controller_ready_index_fifo.sv
// Ordered queue of finished buffer indices; optional replace-newest-when-full for mailbox use.
// Latency: a push shows in count/head one cycle later; a pop retires the head at the next edge.
// Backpressure: a push into a full queue is accepted only with a coincident pop, or overwrites the newest entry when REPLACE=1.
module ready_index_fifo
    import multi_buffer_swap_controller_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int WIDTH   = 2,
    parameter int CNT_W   = 2,
    parameter bit REPLACE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             drop_vld,
    output logic [WIDTH-1:0] drop_dat
);

    localparam int                PTR_W = `CLOG2(DEPTH);
    localparam int                MEM_D = 1 << PTR_W;
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [MEM_D];
    logic [WIDTH-1:0] mem_d [MEM_D];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] newest_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Queue bookkeeping: pop first frees a slot so a full queue can push and pop together.
    always_comb begin
        empty      = (cnt_q == '0);
        full       = (cnt_q == CNT_W'(DEPTH));
        do_pop     = pop_vld && !empty;
        do_push    = push_vld && (!full || do_pop);
        drop_vld   = REPLACE && push_vld && full && !do_pop;
        newest_ptr = (wr_ptr_q == '0) ? LAST : wr_ptr_q - 1'b1;
        drop_dat   = mem_q[newest_ptr];
        head_dat   = mem_q[rd_ptr_q];
        count      = cnt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (drop_vld) begin
            mem_d[newest_ptr] = push_dat;
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < MEM_D; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_buffer_swap_controller.sv
// N-way frame-buffer swap controller: owns raster target, display source and the queue of finished frames.
// Latency: all outputs registered; swap/allocation decisions show one cycle after the deciding edge.
// Backpressure: raster allocation stalls while no buffer is FREE; swaps wait for the vblank level.
module multi_buffer_swap_controller
    import multi_buffer_swap_controller_pkg::*;
#(
    parameter int       NUM_BUFFERS  = 3,
    parameter bit       MAILBOX_MODE = 1'b0,
    parameter int       DROP_CNT_W   = 8,
    localparam int      IDX_W        = `CLOG2(NUM_BUFFERS)
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_raster_in_progress,
    input  logic                  i_frame_buffer_swap_allowed,
    output logic                  o_new_frame,
    output logic [IDX_W-1:0]      o_rasterization_target,
    output logic [IDX_W-1:0]      o_display_source,
    output logic                  o_swap,
    output logic                  o_stall,
    output logic [IDX_W:0]        o_frames_queued,
    output logic [DROP_CNT_W-1:0] o_frames_dropped
);

    // Mailbox keeps only the newest finished frame; FIFO can hold every non-displayed buffer.
    localparam int               Q_DEPTH  = MAILBOX_MODE ? 1 : NUM_BUFFERS - 1;
    localparam int               Q_CNT_W  = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_BUF = IDX_W'(NUM_BUFFERS - 1);

    buf_state_e          buf_state_q [NUM_BUFFERS];
    buf_state_e          buf_state_d [NUM_BUFFERS];
    raster_state_e       state_q, state_d;
    logic [IDX_W-1:0]    target_q, target_d;
    logic [IDX_W-1:0]    display_q, display_d;
    logic                new_frame_q, new_frame_d;
    logic                swap_q, swap_d;
    logic                stall_q, stall_d;
    logic [DROP_CNT_W-1:0] dropped_q, dropped_d;

    logic                q_push, q_pop, q_empty, q_full, q_drop_vld;
    logic [IDX_W-1:0]    q_head, q_drop_dat;
    logic [Q_CNT_W-1:0]  q_count;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;

    // Queue handshakes depend only on registered state so the FIFO's drop output never loops back.
    assign q_push = (state_q == RS_FRAME_FINISHED);
    assign q_pop  = i_frame_buffer_swap_allowed && !q_empty;

    ready_index_fifo #(
        .DEPTH   (Q_DEPTH),
        .WIDTH   (IDX_W),
        .CNT_W   (Q_CNT_W),
        .REPLACE (MAILBOX_MODE)
    ) u_ready_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .push_vld (q_push),
        .push_dat (target_q),
        .pop_vld  (q_pop),
        .head_dat (q_head),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full),
        .drop_vld (q_drop_vld),
        .drop_dat (q_drop_dat)
    );

    // Lowest-index FREE buffer from registered state; a buffer freed this cycle is seen next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (buf_state_q[i] == BUF_FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Raster sequencer, display swap and mailbox drop accounting.
    always_comb begin
        buf_state_d = buf_state_q;
        state_d     = state_q;
        target_d    = target_q;
        display_d   = display_q;
        new_frame_d = new_frame_q;
        swap_d      = 1'b0;
        stall_d     = 1'b0;
        dropped_d   = dropped_q;

        case (state_q)
            RS_FRAME_READY: begin
                new_frame_d = 1'b1;
                if (i_raster_in_progress) begin
                    state_d     = RS_RASTER_IN_PROGRESS;
                    new_frame_d = 1'b0;
                end
            end
            RS_RASTER_IN_PROGRESS: begin
                if (!i_raster_in_progress) begin
                    state_d = RS_FRAME_FINISHED;
                end
            end
            RS_FRAME_FINISHED: begin
                buf_state_d[target_q] = BUF_READY;
                state_d               = RS_ALLOCATE;
            end
            RS_ALLOCATE: begin
                if (free_found) begin
                    buf_state_d[free_idx] = BUF_RENDERING;
                    target_d              = free_idx;
                    new_frame_d           = 1'b1;
                    state_d               = RS_FRAME_READY;
                end else begin
                    stall_d = 1'b1;
                end
            end
            default: begin
                state_d     = RS_FRAME_READY;
                new_frame_d = 1'b1;
            end
        endcase

        // The queue head and the current display buffer are never the allocation candidate.
        if (q_pop) begin
            buf_state_d[display_q] = BUF_FREE;
            buf_state_d[q_head]    = BUF_DISPLAYING;
            display_d              = q_head;
            swap_d                 = 1'b1;
        end

        if (q_drop_vld) begin
            buf_state_d[q_drop_dat] = BUF_FREE;
            if (dropped_q != '1) begin
                dropped_d = dropped_q + 1'b1;
            end
        end
    end

    // All controller state, reset to "buffer 0 rendering, last buffer on screen".
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (i == 0) begin
                    buf_state_q[i] <= BUF_RENDERING;
                end else if (i == NUM_BUFFERS - 1) begin
                    buf_state_q[i] <= BUF_DISPLAYING;
                end else begin
                    buf_state_q[i] <= BUF_FREE;
                end
            end
            state_q     <= RS_FRAME_READY;
            target_q    <= '0;
            display_q   <= LAST_BUF;
            new_frame_q <= 1'b1;
            swap_q      <= 1'b0;
            stall_q     <= 1'b0;
            dropped_q   <= '0;
        end else begin
            buf_state_q <= buf_state_d;
            state_q     <= state_d;
            target_q    <= target_d;
            display_q   <= display_d;
            new_frame_q <= new_frame_d;
            swap_q      <= swap_d;
            stall_q     <= stall_d;
            dropped_q   <= dropped_d;
        end
    end

    // In FIFO mode allocation stalls before the queue can fill, so a lost push means broken bookkeeping.
    assert property (@(posedge i_clk) disable iff (!i_arst_n)
                     MAILBOX_MODE || !(q_push && q_full && !q_pop));

    assign o_new_frame            = new_frame_q;
    assign o_rasterization_target = target_q;
    assign o_display_source       = display_q;
    assign o_swap                 = swap_q;
    assign o_stall                = stall_q;
    assign o_frames_queued        = q_count;
    assign o_frames_dropped       = dropped_q;

endmodule

// File: tb/tb_multi_buffer_swap_controller.sv
// Bench for the swap controller: four configurations side by side on one clock.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_buffer_swap_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    logic raster_in [4];
    logic swap_in   [4];

    // 0: N=3 FIFO, 1: N=2 FIFO, 2: N=3 mailbox, 3: N=3 mailbox with 2-bit drop counter
    logic       n3_nf, n3_swap, n3_stall;
    logic [1:0] n3_tgt, n3_disp;
    logic [2:0] n3_q;
    logic [7:0] n3_drop;

    logic       n2_nf, n2_swap, n2_stall;
    logic [0:0] n2_tgt, n2_disp;
    logic [1:0] n2_q;
    logic [7:0] n2_drop;

    logic       mb_nf, mb_swap, mb_stall;
    logic [1:0] mb_tgt, mb_disp;
    logic [2:0] mb_q;
    logic [7:0] mb_drop;

    logic       st_nf, st_swap, st_stall;
    logic [1:0] st_tgt, st_disp;
    logic [2:0] st_q;
    logic [1:0] st_drop;

    multi_buffer_swap_controller #(.NUM_BUFFERS(3), .MAILBOX_MODE(1'b0), .DROP_CNT_W(8)) u_n3 (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_raster_in_progress(raster_in[0]), .i_frame_buffer_swap_allowed(swap_in[0]),
        .o_new_frame(n3_nf), .o_rasterization_target(n3_tgt), .o_display_source(n3_disp),
        .o_swap(n3_swap), .o_stall(n3_stall), .o_frames_queued(n3_q), .o_frames_dropped(n3_drop));

    multi_buffer_swap_controller #(.NUM_BUFFERS(2), .MAILBOX_MODE(1'b0), .DROP_CNT_W(8)) u_n2 (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_raster_in_progress(raster_in[1]), .i_frame_buffer_swap_allowed(swap_in[1]),
        .o_new_frame(n2_nf), .o_rasterization_target(n2_tgt), .o_display_source(n2_disp),
        .o_swap(n2_swap), .o_stall(n2_stall), .o_frames_queued(n2_q), .o_frames_dropped(n2_drop));

    multi_buffer_swap_controller #(.NUM_BUFFERS(3), .MAILBOX_MODE(1'b1), .DROP_CNT_W(8)) u_mb (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_raster_in_progress(raster_in[2]), .i_frame_buffer_swap_allowed(swap_in[2]),
        .o_new_frame(mb_nf), .o_rasterization_target(mb_tgt), .o_display_source(mb_disp),
        .o_swap(mb_swap), .o_stall(mb_stall), .o_frames_queued(mb_q), .o_frames_dropped(mb_drop));

    multi_buffer_swap_controller #(.NUM_BUFFERS(3), .MAILBOX_MODE(1'b1), .DROP_CNT_W(2)) u_st (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_raster_in_progress(raster_in[3]), .i_frame_buffer_swap_allowed(swap_in[3]),
        .o_new_frame(st_nf), .o_rasterization_target(st_tgt), .o_display_source(st_disp),
        .o_swap(st_swap), .o_stall(st_stall), .o_frames_queued(st_q), .o_frames_dropped(st_drop));

    typedef struct packed {
        int nf;
        int swp;
        int stall;
        int tgt;
        int disp;
        int q;
        int drop;
    } obs_t;

    obs_t obs [4];
    assign obs[0] = '{nf: int'(n3_nf), swp: int'(n3_swap), stall: int'(n3_stall), tgt: int'(n3_tgt),
                      disp: int'(n3_disp), q: int'(n3_q), drop: int'(n3_drop)};
    assign obs[1] = '{nf: int'(n2_nf), swp: int'(n2_swap), stall: int'(n2_stall), tgt: int'(n2_tgt),
                      disp: int'(n2_disp), q: int'(n2_q), drop: int'(n2_drop)};
    assign obs[2] = '{nf: int'(mb_nf), swp: int'(mb_swap), stall: int'(mb_stall), tgt: int'(mb_tgt),
                      disp: int'(mb_disp), q: int'(mb_q), drop: int'(mb_drop)};
    assign obs[3] = '{nf: int'(st_nf), swp: int'(st_swap), stall: int'(st_stall), tgt: int'(st_tgt),
                      disp: int'(st_disp), q: int'(st_q), drop: int'(st_drop)};

    int vec_cnt = 0;
    int err_cnt = 0;

    // Expected display source for each upcoming swap, per instance.
    int sb0 [$];
    int sb1 [$];
    int sb2 [$];
    int sb3 [$];

    task automatic check_eq(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the buffer a finished frame should later be shown from; mailbox replaces the pending one.
    task automatic push_exp(input int id, input int b, input bit replace);
        int tmp;
        case (id)
            0: begin if (replace && sb0.size() > 0) tmp = sb0.pop_back(); sb0.push_back(b); end
            1: begin if (replace && sb1.size() > 0) tmp = sb1.pop_back(); sb1.push_back(b); end
            2: begin if (replace && sb2.size() > 0) tmp = sb2.pop_back(); sb2.push_back(b); end
            default: begin if (replace && sb3.size() > 0) tmp = sb3.pop_back(); sb3.push_back(b); end
        endcase
    endtask

    task automatic sb_compare(input int id);
        int n;
        int exp;
        case (id)
            0: n = sb0.size();
            1: n = sb1.size();
            2: n = sb2.size();
            default: n = sb3.size();
        endcase
        if (n == 0) begin
            check_eq($sformatf("i%0d_unexpected_swap", id), obs[id].swp, 0);
        end else begin
            case (id)
                0: exp = sb0.pop_front();
                1: exp = sb1.pop_front();
                2: exp = sb2.pop_front();
                default: exp = sb3.pop_front();
            endcase
            check_eq($sformatf("i%0d_swap_src", id), obs[id].disp, exp);
        end
    endtask

    // Every o_swap pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            for (int id = 0; id < 4; id++) begin
                if (obs[id].swp != 0) sb_compare(id);
            end
        end
    end

    task automatic do_frame(input int id);
        raster_in[id] = 1'b1;
        tick(1);
        raster_in[id] = 1'b0;
        tick(1);
    endtask

    task automatic wait_nf(input int id, input string tag);
        int n = 0;
        while (obs[id].nf == 0 && n < 20) begin
            tick(1);
            n++;
        end
        check_eq(tag, obs[id].nf, 1);
    endtask

    task automatic vblank_pulse(input int id);
        swap_in[id] = 1'b1;
        tick(1);
        swap_in[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            raster_in[i] = 1'b0;
            swap_in[i]   = 1'b0;
        end
        arst_n = 1'b0;
        tick(2);
        arst_n = 1'b1;
        tick(1);

        // Asynchronous reset in the middle of a frame.
        raster_in[0] = 1'b1;
        tick(2);
        check_eq("n3_busy_nf", obs[0].nf, 0);
        #2 arst_n = 1'b0;
        #1;
        check_eq("rst_tgt",   obs[0].tgt, 0);
        check_eq("rst_disp",  obs[0].disp, 2);
        check_eq("rst_nf",    obs[0].nf, 1);
        check_eq("rst_q",     obs[0].q, 0);
        check_eq("rst_stall", obs[0].stall, 0);
        check_eq("rst_swap",  obs[0].swp, 0);
        check_eq("rst_drop",  obs[0].drop, 0);
        check_eq("rst_n2_disp", obs[1].disp, 1);
        raster_in[0] = 1'b0;
        tick(1);
        arst_n = 1'b1;
        tick(2);

        // N=3 FIFO: first frame queues, next target is buffer 1 without stalling.
        push_exp(0, 0, 1'b0);
        do_frame(0);
        wait_nf(0, "n3_f0_nf");
        check_eq("n3_f0_tgt",   obs[0].tgt, 1);
        check_eq("n3_f0_stall", obs[0].stall, 0);
        check_eq("n3_f0_q",     obs[0].q, 1);
        check_eq("n3_f0_disp",  obs[0].disp, 2);
        vblank_pulse(0);
        check_eq("n3_sw0_pulse", obs[0].swp, 1);
        check_eq("n3_sw0_disp",  obs[0].disp, 0);
        check_eq("n3_sw0_q",     obs[0].q, 0);
        tick(1);
        check_eq("n3_sw0_pulse_end", obs[0].swp, 0);

        // Buffer 2 was released by that swap, so it is the next allocation.
        push_exp(0, 1, 1'b0);
        do_frame(0);
        wait_nf(0, "n3_f1_nf");
        check_eq("n3_f1_tgt", obs[0].tgt, 2);
        vblank_pulse(0);
        check_eq("n3_sw1_disp", obs[0].disp, 1);

        // Frame finishes while vblank is already high and the queue is empty.
        push_exp(0, 2, 1'b0);
        raster_in[0] = 1'b1;
        tick(1);
        raster_in[0] = 1'b0;
        swap_in[0]   = 1'b1;
        tick(1);
        tick(1);
        check_eq("n3_coinc_noswap", obs[0].swp, 0);
        check_eq("n3_coinc_q",      obs[0].q, 1);
        tick(1);
        check_eq("n3_coinc_swap", obs[0].swp, 1);
        check_eq("n3_coinc_disp", obs[0].disp, 2);
        check_eq("n3_coinc_tgt",  obs[0].tgt, 0);
        swap_in[0] = 1'b0;

        // Two frames queued with no free buffer, then back-to-back swaps.
        push_exp(0, 0, 1'b0);
        do_frame(0);
        wait_nf(0, "n3_f3_nf");
        check_eq("n3_f3_tgt", obs[0].tgt, 1);
        push_exp(0, 1, 1'b0);
        do_frame(0);
        tick(3);
        check_eq("n3_full_stall", obs[0].stall, 1);
        check_eq("n3_full_nf",    obs[0].nf, 0);
        check_eq("n3_full_q",     obs[0].q, 2);
        swap_in[0] = 1'b1;
        tick(2);
        swap_in[0] = 1'b0;
        check_eq("n3_b2b_disp",  obs[0].disp, 1);
        check_eq("n3_b2b_tgt",   obs[0].tgt, 2);
        check_eq("n3_b2b_nf",    obs[0].nf, 1);
        check_eq("n3_b2b_stall", obs[0].stall, 0);
        check_eq("n3_b2b_q",     obs[0].q, 0);

        // N=2 FIFO: classic double buffering waits for vblank.
        push_exp(1, 0, 1'b0);
        do_frame(1);
        tick(3);
        check_eq("n2_stall",    obs[1].stall, 1);
        check_eq("n2_stall_nf", obs[1].nf, 0);
        check_eq("n2_stall_q",  obs[1].q, 1);
        vblank_pulse(1);
        check_eq("n2_sw_disp", obs[1].disp, 0);
        check_eq("n2_sw_nf",   obs[1].nf, 0);
        tick(1);
        check_eq("n2_alloc_tgt",   obs[1].tgt, 1);
        check_eq("n2_alloc_nf",    obs[1].nf, 1);
        check_eq("n2_alloc_stall", obs[1].stall, 0);

        // Mailbox: second frame replaces the first, which is dropped and freed.
        push_exp(2, 0, 1'b0);
        do_frame(2);
        wait_nf(2, "mb_f0_nf");
        check_eq("mb_f0_tgt",  obs[2].tgt, 1);
        check_eq("mb_f0_drop", obs[2].drop, 0);
        push_exp(2, 1, 1'b1);
        do_frame(2);
        wait_nf(2, "mb_f1_nf");
        check_eq("mb_f1_drop", obs[2].drop, 1);
        check_eq("mb_f1_q",    obs[2].q, 1);
        check_eq("mb_f1_tgt",  obs[2].tgt, 0);
        vblank_pulse(2);
        check_eq("mb_sw_disp", obs[2].disp, 1);

        // Narrow drop counter saturates at all-ones.
        for (int k = 0; k < 6; k++) begin
            push_exp(3, k % 2, k > 0);
            do_frame(3);
            wait_nf(3, "sat_nf");
            check_eq($sformatf("sat_drop_%0d", k), obs[3].drop, (k > 3) ? 3 : k);
            check_eq($sformatf("sat_q_%0d", k), obs[3].q, 1);
        end
        vblank_pulse(3);
        check_eq("sat_sw_disp", obs[3].disp, 1);

        tick(3);
        check_eq("sb0_drained", sb0.size(), 0);
        check_eq("sb1_drained", sb1.size(), 0);
        check_eq("sb2_drained", sb2.size(), 0);
        check_eq("sb3_drained", sb3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
